// File: rtl/gpr_file_sb_pkg.sv
// Shared definitions for the general-purpose register file with scoreboard.
// Contents:
//   - default geometry (data width, address width, read-port count)
//   - the init/ready state encoding used by the top-level init engine
// Optional feature macro (defined at build time, not here):
//   GPR_BYPASS_EN - enables write-through forwarding from the write port to the read ports
package gpr_file_sb_pkg;

  localparam int GPR_DEF_DATA_W = 32;
  localparam int GPR_DEF_ADDR_W = 5;
  localparam int GPR_DEF_NUM_RD = 2;

  // INIT walks the array clearing it; READY is terminal until the next reset.
  typedef enum logic {
    GPR_ST_INIT  = 1'b0,
    GPR_ST_READY = 1'b1
  } gpr_state_t;

endpackage

// File: rtl/gpr_file_sb_scoreboard.sv
// Per-register pending-write scoreboard.
// One busy bit per register: set when an instruction targeting the register issues,
// cleared when its result is written back. When both happen to the same register in
// one cycle, the set wins because the issuing instruction is the newer producer.
// Ports:
//   clk       in   system clock
//   reset_    in   asynchronous active-low reset, clears all busy bits
//   set_en    in   set busy[set_addr] (already qualified by the caller)
//   set_addr  in   register to mark pending
//   clr_en    in   clear busy[clr_addr] (already qualified by the caller)
//   clr_addr  in   register whose pending write has completed
//   rd_addr   in   NUM_RD packed lookup addresses
//   rd_busy   out  raw busy bit for each lookup address
module gpr_scoreboard
  import gpr_file_sb_pkg::*;
#(
  parameter int ADDR_W = GPR_DEF_ADDR_W,
  parameter int NUM_RD = GPR_DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy;

  // The set is applied after the clear so a same-address issue overrides the writeback.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      busy <= '0;
    end else begin
      if (clr_en) begin
        busy[clr_addr] <= 1'b0;
      end
      if (set_en) begin
        busy[set_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy[k] = busy[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/gpr_file_sb.sv
// Parametrised general-purpose register file with per-register scoreboard.
// After reset a sequential init engine clears one entry per cycle, so the array itself
// carries no reset and can map onto RAM. Writes and issues are accepted only once the
// engine has reached READY.
// Optional feature macro: GPR_BYPASS_EN - a read that hits the register being written in
// the same cycle returns the new data (and a cleared busy bit) instead of the old value.
// Ports:
//   clk       in   system clock
//   reset_    in   asynchronous active-low reset (restarts init, clears busy bits)
//   ready     out  1 once init has finished
//   rd_addr   in   NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   out  NUM_RD packed read data (combinational), port k at [k*DATA_W +: DATA_W]
//   rd_busy   out  per-port pending-write flag of the addressed register
//   we_       in   active-low write enable
//   wr_addr   in   write address
//   wr_data   in   write data
//   iss_en    in   issue strobe, marks iss_addr pending
//   iss_addr  in   destination register of the issued instruction
module gpr_file_sb
  import gpr_file_sb_pkg::*;
#(
  parameter int DATA_W   = GPR_DEF_DATA_W,
  parameter int ADDR_W   = GPR_DEF_ADDR_W,
  parameter int NUM_RD   = GPR_DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we_,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  gpr_state_t        state;
  gpr_state_t        state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok;
  logic              iss_ok;
  logic [NUM_RD-1:0] sb_busy;
  logic [ADDR_W-1:0] port_addr [NUM_RD];

  assign ready = (state == GPR_ST_READY);

  // Register 0 is neither writable nor issuable when it is hardwired to zero.
  assign wr_ok  = ready && !we_   && !((ZERO_REG != 0) && (wr_addr  == '0));
  assign iss_ok = ready && iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port_addr
    assign port_addr[g] = rd_addr[g*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state   <= GPR_ST_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Init walks every address once; the counter wraps back to 0 on the last clear,
  // which is harmless because it is not used again in READY.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      GPR_ST_INIT: begin
        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt = GPR_ST_READY;
        end
      end
      GPR_ST_READY: begin
        state_nxt = GPR_ST_READY;
      end
      default: begin
        state_nxt = GPR_ST_INIT;
      end
    endcase
  end

  // Single write port into the array; the init engine owns it until READY.
  always_ff @(posedge clk) begin
    if (state == GPR_ST_INIT) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  gpr_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk      (clk),
    .reset_   (reset_),
    .set_en   (iss_ok),
    .set_addr (iss_addr),
    .clr_en   (wr_ok),
    .clr_addr (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (sb_busy)
  );

  // Reads are forced to zero during init because the array still holds stale contents.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (ready && !((ZERO_REG != 0) && (port_addr[k] == '0))) begin
        rd_data[k*DATA_W +: DATA_W] = mem[port_addr[k]];
        rd_busy[k]                  = sb_busy[k];
`ifdef GPR_BYPASS_EN
        if (wr_ok && (port_addr[k] == wr_addr)) begin
          rd_data[k*DATA_W +: DATA_W] = wr_data;
          // A same-cycle issue to this register keeps it pending.
          if (!(iss_ok && (iss_addr == wr_addr))) begin
            rd_busy[k] = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule
